// File: rtl/jacobi_matvec.sv
// Forward evaluator b = A*x in signed fixed point using one shared multiply-accumulate.
// Define JACOBI_MATVEC_SATURATE_EN for saturating output format plus a sticky `sat` flag.
module jacobi_matvec #(
  parameter int unsigned SIZE      = 3,
  parameter int unsigned PRECISION = 16,
  parameter int unsigned POINT     = 8,
  localparam int unsigned N        = PRECISION + POINT
) (
  input  logic                clk,
  input  logic                I_RSTn,
  input  logic                start,
  input  logic signed [N-1:0] A [SIZE][SIZE],
  input  logic signed [N-1:0] x [SIZE],
  output logic signed [N-1:0] b [SIZE],
  output logic                ready,
  output logic                done
`ifdef JACOBI_MATVEC_SATURATE_EN
  , output logic              sat
`endif
);

  localparam int unsigned AW = 2 * N + $clog2(SIZE) + 1;
  localparam int unsigned IW = $clog2(SIZE);
  localparam logic [IW-1:0] Last = IW'(SIZE - 1);

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  state_e                state_q, state_d;
  logic signed [N-1:0]   a_q [SIZE][SIZE];
  logic signed [N-1:0]   a_d [SIZE][SIZE];
  logic signed [N-1:0]   x_q [SIZE];
  logic signed [N-1:0]   x_d [SIZE];
  logic signed [N-1:0]   b_q [SIZE];
  logic signed [N-1:0]   b_d [SIZE];
  logic [IW-1:0]         i_q, i_d, j_q, j_d;
  logic [AW-1:0]         acc_q, acc_d;
  logic                  done_q, done_d, ready_q, ready_d;
  logic                  sat_q, sat_d;

  logic signed [2*N-1:0] prod, prod_sh;
  logic [AW-1:0]         sum;
  logic [N-1:0]          fmt_val;
  logic                  row_sat;

  always_comb begin
    prod    = a_q[i_q][j_q] * x_q[j_q];
    prod_sh = prod >>> POINT;
    sum     = (j_q == '0 ? '0 : acc_q) + {{(AW - 2 * N){prod_sh[2*N-1]}}, prod_sh};
  end

`ifdef JACOBI_MATVEC_SATURATE_EN
  // Out of range whenever the bits above the result's sign bit disagree with the true sign.
  logic sat_hi, sat_lo;
  always_comb begin
    sat_hi  = !sum[AW-1] && (|sum[AW-2:N-1]);
    sat_lo  = sum[AW-1] && !(&sum[AW-2:N-1]);
    row_sat = sat_hi || sat_lo;
    if (sat_hi) begin
      fmt_val = {1'b0, {(N - 1){1'b1}}};
    end else if (sat_lo) begin
      fmt_val = {1'b1, {(N - 1){1'b0}}};
    end else begin
      fmt_val = sum[N-1:0];
    end
  end
  assign sat = sat_q;
`else
  logic unused_sum;
  assign unused_sum = ^sum[AW-1:N];
  assign row_sat    = 1'b0;
  assign fmt_val    = sum[N-1:0];
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    x_d     = x_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = A;
          x_d     = x;
          i_d     = '0;
          j_d     = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
          ready_d = 1'b0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = sum;
        if (j_q == Last) begin
          b_d[i_q] = fmt_val;
          sat_d    = sat_q | row_sat;
          j_d      = '0;
          if (i_q == Last) begin
            i_d     = '0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      StDone: begin
        ready_d = 1'b1;
        state_d = StIdle;
      end
      default: begin
        ready_d = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!I_RSTn) begin
      state_q <= StIdle;
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          a_q[r][c] <= '0;
        end
        x_q[r] <= '0;
        b_q[r] <= '0;
      end
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      x_q     <= x_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      sat_q   <= sat_d;
    end
  end

  assign b     = b_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule

// File: tb/tb_jacobi_matvec.sv
// Directed self-checking bench for jacobi_matvec (SIZE=3, N=24).
module tb_jacobi_matvec;

  logic               clk = 1'b0;
  logic               I_RSTn;
  logic               start;
  logic signed [23:0] A [3][3];
  logic signed [23:0] x [3];
  logic signed [23:0] b [3];
  logic               ready;
  logic               done;
`ifdef JACOBI_MATVEC_SATURATE_EN
  logic               sat;
`endif

  int errs   = 0;
  int checks = 0;

  jacobi_matvec #(.SIZE(3), .PRECISION(16), .POINT(8)) dut (
    .clk   (clk),
    .I_RSTn(I_RSTn),
    .start (start),
    .A     (A),
    .x     (x),
    .b     (b),
    .ready (ready),
    .done  (done)
`ifdef JACOBI_MATVEC_SATURATE_EN
    , .sat (sat)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_a(input logic signed [23:0] v);
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) A[r][c] = v;
  endtask

  task automatic set_identity();
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) A[r][c] = (r == c) ? 24'sd256 : 24'sd0;
    x[0] = 24'sd256;
    x[1] = 24'sd512;
    x[2] = -24'sd768;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs exactly ncyc ticks after acceptance; records first done cycle and ready around it.
  task automatic watch(input int ncyc, output int lat, output int nd,
                       output logic rdy_at, output logic rdy_after);
    lat = -1;
    nd = 0;
    rdy_at = 1'bx;
    rdy_after = 1'bx;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      if (lat >= 0 && c == lat + 1) rdy_after = ready;
      if (done) begin
        nd++;
        if (lat < 0) begin
          lat = c;
          rdy_at = ready;
        end
      end
    end
  endtask

  task automatic test_reset();
    I_RSTn = 1'b0;
    start  = 1'b0;
    fill_a(24'sd0);
    for (int i = 0; i < 3; i++) x[i] = 24'sd0;
    tick();
    tick();
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL reset_hs: ready=%b done=%b, required ready=1 done=0", ready, done);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (b[i] !== 24'sd0) begin
        errs++;
        $display("FAIL reset_b[%0d]: got %0d, required 0", i, b[i]);
      end
    end
    I_RSTn = 1'b1;
    tick();
  endtask

  task automatic test_identity();
    int lat, nd;
    logic ra, rb;
    logic signed [23:0] exp [3];
    exp[0] = 24'sd256;
    exp[1] = 24'sd512;
    exp[2] = -24'sd768;
    set_identity();
    pulse_start();
    checks++;
    if (ready !== 1'b0) begin
      errs++;
      $display("FAIL ident_busy: ready=%b, required 0", ready);
    end
    fill_a(24'sd999);  // post-capture changes must not matter
    x[0] = 24'sd7;
    watch(12, lat, nd, ra, rb);
    checks++;
    if (lat !== 9 || nd !== 1) begin
      errs++;
      $display("FAIL ident_latency: done at %0d count %0d, required 9 and 1", lat, nd);
    end
    checks++;
    if (ra !== 1'b0 || rb !== 1'b1) begin
      errs++;
      $display("FAIL ident_ready: at done %b after %b, required 0 then 1", ra, rb);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (b[i] !== exp[i]) begin
        errs++;
        $display("FAIL ident_b[%0d]: got %0d, required %0d", i, b[i], exp[i]);
      end
    end
  endtask

  task automatic test_uniform(input logic signed [23:0] av, input logic signed [23:0] xv,
                              input logic signed [23:0] ev, input logic exp_sat, input string nm);
    int lat, nd;
    logic ra, rb;
    fill_a(av);
    for (int i = 0; i < 3; i++) x[i] = xv;
    pulse_start();
    watch(11, lat, nd, ra, rb);
    checks++;
    if (lat !== 9 || nd !== 1) begin
      errs++;
      $display("FAIL %s_latency: done at %0d count %0d, required 9 and 1", nm, lat, nd);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (b[i] !== ev) begin
        errs++;
        $display("FAIL %s_b[%0d]: got %0d, required %0d", nm, i, b[i], ev);
      end
    end
`ifdef JACOBI_MATVEC_SATURATE_EN
    checks++;
    if (sat !== exp_sat) begin
      errs++;
      $display("FAIL %s_sat: got %b, required %b", nm, sat, exp_sat);
    end
`else
    if (exp_sat === 1'bx) $display("unexpected sat flag");
`endif
  endtask

  task automatic test_start_ignored();
    int lat, nd;
    logic ra, rb;
    logic signed [23:0] exp [3];
    exp[0] = 24'sd256;
    exp[1] = 24'sd512;
    exp[2] = -24'sd768;
    set_identity();
    pulse_start();
    tick();
    tick();
    tick();
    fill_a(24'sd512);
    pulse_start();
    watch(12, lat, nd, ra, rb);
    checks++;
    if (lat !== 5 || nd !== 1) begin
      errs++;
      $display("FAIL ignore_done: done at %0d count %0d, required 5 and 1", lat, nd);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (b[i] !== exp[i]) begin
        errs++;
        $display("FAIL ignore_b[%0d]: got %0d, required %0d", i, b[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, nd;
    logic ra, rb;
    fill_a(24'sd512);
    for (int i = 0; i < 3; i++) x[i] = 24'sd256;
    pulse_start();
    nd = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (done) nd++;
    end
    I_RSTn = 1'b0;
    tick();
    I_RSTn = 1'b1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || nd !== 0) begin
      errs++;
      $display("FAIL abort_hs: ready=%b done=%b early_dones=%0d, required 1 0 0", ready, done, nd);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (b[i] !== 24'sd0) begin
        errs++;
        $display("FAIL abort_b[%0d]: got %0d, required 0", i, b[i]);
      end
    end
    test_uniform(-24'sd256, 24'sd1, -24'sd3, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic signed [23:0] first [3];
    logic signed [23:0] exp [3];
    exp[0] = 24'sd256;
    exp[1] = 24'sd512;
    exp[2] = -24'sd768;
    d1 = -1;
    d2 = -1;
    set_identity();
    start = 1'b1;
    tick();
    fill_a(24'sd512);
    for (int i = 0; i < 3; i++) x[i] = 24'sd256;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done) begin
        if (d1 < 0) begin
          d1 = c;
          first = b;
        end else if (d2 < 0) begin
          d2 = c;
        end
      end
    end
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (d1 !== 9 || d2 !== 20) begin
      errs++;
      $display("FAIL b2b_timing: dones at %0d and %0d, required 9 and 20", d1, d2);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (first[i] !== exp[i] || b[i] !== 24'sd1536) begin
        errs++;
        $display("FAIL b2b_b[%0d]: got %0d then %0d, required %0d then 1536",
                 i, first[i], b[i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_uniform(24'sd512, 24'sd256, 24'sd1536, 1'b0, "scale");
    test_uniform(-24'sd256, 24'sd1, -24'sd3, 1'b0, "neg");
`ifdef JACOBI_MATVEC_SATURATE_EN
    test_uniform(24'sh400000, 24'sh400000, 24'sh7FFFFF, 1'b1, "ovf");
`else
    test_uniform(24'sh400000, 24'sh400000, 24'sd0, 1'b1, "ovf");
`endif
    test_uniform(24'sd512, 24'sd256, 24'sd1536, 1'b0, "sat_clear");
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
